// File: rtl/alarm_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_tone_sequencer
//  Description : Alarm buzzer sequencer with on/off cadence, snooze and lockout.
//  Revision    : 1.0
// ============================================================================
module alarm_tone_sequencer #(
    parameter int TONE_HALF    = 5000,
    parameter int TICK_DIV     = 15_750_000,
    parameter int RING_TICKS   = 120,
    parameter int SNOOZE_TICKS = 600,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_req,
    input  logic       stop_pulse,
    input  logic       snooze_pulse,
    output logic       buzzer_out,
    output logic       ringing,
    output logic       snoozed,
    output logic [1:0] snooze_cnt
);

    localparam int c_tone_w = (TONE_HALF    > 1) ? $clog2(TONE_HALF)    : 1;
    localparam int c_tick_w = (TICK_DIV     > 1) ? $clog2(TICK_DIV)     : 1;
    localparam int c_ring_w = (RING_TICKS   > 1) ? $clog2(RING_TICKS)   : 1;
    localparam int c_snz_w  = (SNOOZE_TICKS > 1) ? $clog2(SNOOZE_TICKS) : 1;

    localparam logic [c_tone_w-1:0] c_tone_last  = c_tone_w'(TONE_HALF - 1);
    localparam logic [c_tick_w-1:0] c_tick_last  = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_ring_w-1:0] c_ring_last  = c_ring_w'(RING_TICKS - 1);
    localparam logic [c_snz_w-1:0]  c_snz_last   = c_snz_w'(SNOOZE_TICKS - 1);
    localparam logic [1:0]          c_max_snooze = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RING    = 2'd1,
        ST_SNOOZE  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_tone_w-1:0] r_tone_cnt;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [c_ring_w-1:0] r_ring_cnt;
    logic [c_snz_w-1:0]  r_snz_ticks;
    logic                r_tone_q;
    logic                r_phase_on;
    logic [1:0]          r_snooze_cnt;

    logic w_tone_wrap;
    logic w_tick_wrap;
    logic w_ring_done;
    logic w_snz_done;
    logic w_snooze_ok;
    logic w_enter_ring;
    logic w_take_snooze;
    logic w_clear_snooze;
    logic w_stay;

    assign w_tone_wrap = (r_tone_cnt == c_tone_last);
    assign w_tick_wrap = (r_tick_cnt == c_tick_last);
    assign w_ring_done = w_tick_wrap && (r_ring_cnt == c_ring_last);
    assign w_snz_done  = w_tick_wrap && (r_snz_ticks == c_snz_last);
    assign w_snooze_ok = snooze_pulse && (r_snooze_cnt < c_max_snooze);
    assign w_stay      = (w_state_next == r_state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Exit priority in RING: stop, window end, timeout, snooze.
    always_comb begin
        w_state_next   = r_state;
        w_enter_ring   = 1'b0;
        w_take_snooze  = 1'b0;
        w_clear_snooze = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (alarm_req) begin
                    w_state_next = ST_RING;
                    w_enter_ring = 1'b1;
                end
            end
            ST_RING: begin
                if (stop_pulse) begin
                    w_state_next = ST_LOCKOUT;
                end else if (!alarm_req) begin
                    w_state_next   = ST_IDLE;
                    w_clear_snooze = 1'b1;
                end else if (w_ring_done) begin
                    w_state_next = ST_LOCKOUT;
                end else if (w_snooze_ok) begin
                    w_state_next  = ST_SNOOZE;
                    w_take_snooze = 1'b1;
                end
            end
            ST_SNOOZE: begin
                if (stop_pulse) begin
                    w_state_next = ST_LOCKOUT;
                end else if (w_snz_done) begin
                    w_state_next = ST_RING;
                    w_enter_ring = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (!alarm_req) begin
                    w_state_next   = ST_IDLE;
                    w_clear_snooze = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt  <= '0;
            r_snz_ticks <= '0;
        end else if (!w_stay) begin
            r_tick_cnt  <= '0;
            r_snz_ticks <= '0;
        end else if (r_state == ST_RING || r_state == ST_SNOOZE) begin
            r_tick_cnt <= w_tick_wrap ? '0 : r_tick_cnt + 1'b1;
            if (r_state == ST_SNOOZE && w_tick_wrap && r_snz_ticks != c_snz_last) begin
                r_snz_ticks <= r_snz_ticks + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tone_cnt <= '0;
            r_ring_cnt <= '0;
            r_tone_q   <= 1'b0;
            r_phase_on <= 1'b1;
        end else if (w_enter_ring) begin
            r_tone_cnt <= '0;
            r_ring_cnt <= '0;
            r_tone_q   <= 1'b1;
            r_phase_on <= 1'b1;
        end else if (r_state == ST_RING && w_stay) begin
            r_tone_cnt <= w_tone_wrap ? '0 : r_tone_cnt + 1'b1;
            if (w_tone_wrap) begin
                r_tone_q <= ~r_tone_q;
            end
            if (w_tick_wrap) begin
                r_phase_on <= ~r_phase_on;
                if (r_ring_cnt != c_ring_last) begin
                    r_ring_cnt <= r_ring_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snooze_cnt <= 2'd0;
        end else if (w_clear_snooze) begin
            r_snooze_cnt <= 2'd0;
        end else if (w_take_snooze) begin
            r_snooze_cnt <= r_snooze_cnt + 2'd1;
        end
    end

    // Buzzer lags the state it reflects by one cycle; status flags track the new state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buzzer_out <= 1'b0;
            ringing    <= 1'b0;
            snoozed    <= 1'b0;
        end else begin
            buzzer_out <= (r_state == ST_RING) && r_phase_on && r_tone_q;
            ringing    <= (w_state_next == ST_RING);
            snoozed    <= (w_state_next == ST_SNOOZE);
        end
    end

    assign snooze_cnt = r_snooze_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alarm_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_tone_sequencer
//  Description : Randomized self-checking bench against a time-based model.
//  Revision    : 1.0
// ============================================================================
module tb_alarm_tone_sequencer;

    localparam int TONE_HALF    = 2;
    localparam int TICK_DIV     = 8;
    localparam int RING_TICKS   = 4;
    localparam int SNOOZE_TICKS = 3;
    localparam int MAX_SNOOZE   = 2;

    localparam int c_m_idle = 0;
    localparam int c_m_ring = 1;
    localparam int c_m_snz  = 2;
    localparam int c_m_lock = 3;

    logic       clk;
    logic       reset;
    logic       alarm_req;
    logic       stop_pulse;
    logic       snooze_pulse;
    logic       buzzer_out;
    logic       ringing;
    logic       snoozed;
    logic [1:0] snooze_cnt;

    int n_checks;
    int n_pass;

    int m_mode;
    int m_t;
    int m_snz;
    int exp_buzz;

    alarm_tone_sequencer #(
        .TONE_HALF   (TONE_HALF),
        .TICK_DIV    (TICK_DIV),
        .RING_TICKS  (RING_TICKS),
        .SNOOZE_TICKS(SNOOZE_TICKS),
        .MAX_SNOOZE  (MAX_SNOOZE)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .alarm_req   (alarm_req),
        .stop_pulse  (stop_pulse),
        .snooze_pulse(snooze_pulse),
        .buzzer_out  (buzzer_out),
        .ringing     (ringing),
        .snoozed     (snoozed),
        .snooze_cnt  (snooze_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = c_m_idle;
        m_t      = 0;
        m_snz    = 0;
        exp_buzz = 0;
    endtask

    // Behaviour expressed as elapsed time since entering the current mode.
    task automatic model_step(input bit req, input bit stp, input bit snz);
        int nmode;
        exp_buzz = (m_mode == c_m_ring && ((m_t / TICK_DIV) % 2) == 0
                    && ((m_t / TONE_HALF) % 2) == 0) ? 1 : 0;
        nmode = m_mode;
        case (m_mode)
            c_m_idle: if (req) nmode = c_m_ring;
            c_m_ring: begin
                if (stp) nmode = c_m_lock;
                else if (!req) begin
                    nmode = c_m_idle;
                    m_snz = 0;
                end else if (m_t + 1 >= RING_TICKS * TICK_DIV) nmode = c_m_lock;
                else if (snz && m_snz < MAX_SNOOZE) begin
                    nmode = c_m_snz;
                    m_snz++;
                end
            end
            c_m_snz: begin
                if (stp) nmode = c_m_lock;
                else if (m_t + 1 >= SNOOZE_TICKS * TICK_DIV) nmode = c_m_ring;
            end
            default: begin
                if (!req) begin
                    nmode = c_m_idle;
                    m_snz = 0;
                end
            end
        endcase
        if (nmode != m_mode) m_t = 0;
        else m_t++;
        m_mode = nmode;
    endtask

    task automatic check_outputs(input string phase);
        check({phase, ".buzzer"},  int'(buzzer_out), exp_buzz);
        check({phase, ".ringing"}, int'(ringing),    (m_mode == c_m_ring) ? 1 : 0);
        check({phase, ".snoozed"}, int'(snoozed),    (m_mode == c_m_snz) ? 1 : 0);
        check({phase, ".snz_cnt"}, int'(snooze_cnt), m_snz);
    endtask

    task automatic cycle(input bit req, input bit stp, input bit snz, input string phase);
        alarm_req    = req;
        stop_pulse   = stp;
        snooze_pulse = snz;
        @(posedge clk);
        model_step(req, stp, snz);
        #1;
        check_outputs(phase);
    endtask

    task automatic cycles(input int n, input bit req, input string phase);
        for (int i = 0; i < n; i++) cycle(req, 1'b0, 1'b0, phase);
    endtask

    task automatic async_reset(input string phase);
        reset = 1'b1;
        #2;
        model_reset();
        check_outputs(phase);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        alarm_req    = 1'b0;
        stop_pulse   = 1'b0;
        snooze_pulse = 1'b0;
        model_reset();
        #13;
        check_outputs("reset");
        @(posedge clk);
        #1;
        check_outputs("reset_hold");
        reset = 1'b0;

        cycles(3, 1'b0, "idle");
        cycles(40, 1'b1, "timeout");
        cycles(3, 1'b0, "lock_exit");

        cycles(5, 1'b1, "snz_a");
        cycle(1'b1, 1'b0, 1'b1, "snz1");
        cycles(30, 1'b1, "snz_b");
        cycle(1'b1, 1'b0, 1'b1, "snz2");
        cycles(28, 1'b1, "snz_c");
        cycle(1'b1, 1'b0, 1'b1, "snz3_ignored");
        cycles(2, 1'b1, "snz_d");
        cycle(1'b1, 1'b1, 1'b1, "stop_and_snz");
        cycles(3, 1'b1, "lockout");
        cycles(3, 1'b0, "lock_exit2");

        cycles(10, 1'b1, "ring_drop_a");
        cycles(3, 1'b0, "ring_drop_b");

        cycles(6, 1'b1, "pre_reset");
        async_reset("reset_mid_ring");
        cycles(3, 1'b1, "post_reset");

        cycles(3, 1'b1, "pre_reset_snz");
        cycle(1'b1, 1'b0, 1'b1, "snz_before_reset");
        cycles(4, 1'b1, "in_snz");
        async_reset("reset_mid_snooze");
        cycles(3, 1'b0, "post_reset2");

        begin
            bit req;
            req = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                bit stp;
                bit snz;
                if ($urandom_range(0, 99) < 2) req = ~req;
                stp = ($urandom_range(0, 99) < 2);
                snz = ($urandom_range(0, 99) < 6);
                cycle(req, stp, snz, "rand");
                if ($urandom_range(0, 999) < 2) async_reset("rand_reset");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
